// File: rtl/memory_burst_ctrl_if.sv
// Request/data bus between the control unit and the burst-capable scratch RAM.
// The master side issues bursts and streams write data. The slave side returns read beats and status.
interface memory_burst_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int LEN_W  = 4
);
    logic              mem_enable;
    logic              read_write;
    logic [ADDR_W-1:0] address_bus;
    logic [LEN_W-1:0]  burst_len;
    logic [DATA_W-1:0] data_bus_in;
    logic              data_in_valid;
    logic [DATA_W-1:0] data_bus_out;
    logic              data_out_valid;
    logic              busy;
    logic              done;
    logic              overrun;

    modport master (
        output mem_enable, read_write, address_bus, burst_len, data_bus_in, data_in_valid,
        input  data_bus_out, data_out_valid, busy, done, overrun
    );

    modport slave (
        input  mem_enable, read_write, address_bus, burst_len, data_bus_in, data_in_valid,
        output data_bus_out, data_out_valid, busy, done, overrun
    );
endinterface

// File: rtl/memory_burst_ctrl.sv
// Single-port synchronous scratch RAM with a burst engine.
// The address auto-increments and wraps. Reset clears the whole array.
module memory_burst_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int LEN_W  = 4
) (
    input logic              clk,
    input logic              rst,
    memory_burst_ctrl_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic [LEN_W-1:0]  rem_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept, rd_beat, wr_beat, last_beat, overrun_d;
    logic [DATA_W-1:0] dout_q;
    logic              dvalid_q, done_q, overrun_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        rd_beat   = 1'b0;
        wr_beat   = 1'b0;
        last_beat = 1'b0;
        overrun_d = bus.mem_enable && (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (bus.mem_enable) begin
                    accept  = 1'b1;
                    state_d = bus.read_write ? RD : WR;
                end
            end
            RD: begin
                rd_beat   = 1'b1;
                last_beat = (rem_q == LEN_W'(1));
                if (last_beat) state_d = IDLE;
            end
            WR: begin
                // A write beat only happens when data is presented; otherwise the burst waits.
                if (bus.data_in_valid) begin
                    wr_beat   = 1'b1;
                    last_beat = (rem_q == LEN_W'(1));
                    if (last_beat) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            ptr_q     <= '0;
            rem_q     <= '0;
            dout_q    <= '0;
            dvalid_q  <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (accept) begin
                ptr_q <= bus.address_bus;
                rem_q <= (bus.burst_len == '0) ? LEN_W'(1) : bus.burst_len;
            end else if (rd_beat || wr_beat) begin
                ptr_q <= ptr_q + ADDR_W'(1);
                rem_q <= rem_q - LEN_W'(1);
            end
            if (wr_beat) mem[ptr_q] <= bus.data_bus_in;
            // The read bus is forced to zero outside a valid beat.
            dvalid_q  <= rd_beat;
            dout_q    <= rd_beat ? mem[ptr_q] : '0;
            done_q    <= last_beat;
            overrun_q <= overrun_d;
        end
    end

    assign bus.data_bus_out   = dout_q;
    assign bus.data_out_valid = dvalid_q;
    assign bus.busy           = (state_q != IDLE);
    assign bus.done           = done_q;
    assign bus.overrun        = overrun_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst && rd_beat) $display("READ  addr=%0h data=%0h", ptr_q, mem[ptr_q]);
        if (!rst && wr_beat) $display("WRITE addr=%0h data=%0h", ptr_q, bus.data_bus_in);
    end
`endif
endmodule
